// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller.
// Loopback build option: SPI_LOOPBACK_EN.
package spi_pkg;

  localparam int WORD_W      = 32;
  localparam int CLK_DIV_DEF = 4;
  localparam int HALF_N      = 2 * WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI master.
// Emits a one-cycle tick every DIV cycles while not cleared.
module spi_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  // Free-running modulo-DIV counter, held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/spi_master_ctl.sv
// Mode-0 SPI master: one 32-bit MSB-first transfer per start edge.
// Define SPI_LOOPBACK_EN to receive from mosi_o instead of miso_i.
module spi_master_ctl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [WORD_W-1:0] spi_data_i,
  input  logic              spi_start_i,
  input  logic [1:0]        spi_sel_i,
  output logic [WORD_W-1:0] spi_data_o,
  output logic              spi_done_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [3:0]        cs_n_o
);

  localparam logic [5:0] LAST_HALF = 6'(HALF_N - 1);

  state_t            state;
  state_t            nxt;
  logic              start_q;
  logic              arm;
  logic              detect;
  logic              tick;
  logic              busy;
  logic              din;
  logic [1:0]        sel_q;
  logic [5:0]        half;
  logic [WORD_W-1:0] tx;
  logic [WORD_W-1:0] rx;

`ifdef SPI_LOOPBACK_EN
  wire unused_miso = miso_i;
  assign din = mosi_o;
`else
  assign din = miso_i;
`endif

  assign busy   = (state == SETUP) || (state == SHIFT) ||
                  (state == HOLD);
  assign busy_o = busy;
  assign detect = (state == IDLE) && spi_start_i &&
                  !start_q && arm;
  assign mosi_o     = tx[WORD_W-1];
  assign spi_done_o = (state == DONE);

  spi_clk_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk   (clk_i),
    .rst_n (reset_i),
    .clr   (!busy),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= nxt;
  end

  // Next-state decode.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (detect) nxt = SETUP;
      SETUP: if (tick) nxt = SHIFT;
      SHIFT: if (tick && half == LAST_HALF) nxt = HOLD;
      HOLD:  if (tick) nxt = DONE;
      DONE:  if (!spi_start_i) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Chip select follows the latched index while busy.
  always_comb begin
    cs_n_o = 4'hF;
    if (busy) cs_n_o[sel_q] = 1'b0;
  end

  // Start edge tracking, shift registers and sclk generation.
  // arm stays low after reset until start is seen low once.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      start_q    <= 1'b0;
      arm        <= 1'b0;
      sclk_o     <= 1'b0;
      sel_q      <= '0;
      half       <= '0;
      tx         <= '0;
      rx         <= '0;
      spi_data_o <= '0;
    end else begin
      start_q <= spi_start_i;
      if (!spi_start_i) arm <= 1'b1;
      if (detect) begin
        tx     <= spi_data_i;
        sel_q  <= spi_sel_i;
        rx     <= '0;
        half   <= '0;
        sclk_o <= 1'b0;
      end
      if (state == SHIFT && tick) begin
        sclk_o <= ~sclk_o;
        half   <= half + 6'd1;
        if (!sclk_o) begin
          rx <= {rx[WORD_W-2:0], din};
        end else if (half != LAST_HALF) begin
          tx <= {tx[WORD_W-2:0], 1'b0};
        end
      end
      if (state == HOLD && tick) spi_data_o <= rx;
    end
  end

endmodule
